// File: rtl/ram_stream_pkg.sv
// Shared types for the RAM block-stream controller and its read-path skid buffer.
package ram_stream_pkg;

    // Controller sequencing: idle, streaming into RAM, streaming out of RAM, completion pulse
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Command direction as seen on cmd_dir
    typedef enum logic {
        DIR_READ  = 1'b0,
        DIR_WRITE = 1'b1
    } dir_t;

    // Number of read words that may be buffered or in flight at once
    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry FIFO that absorbs the one-cycle RAM read latency so the read
// stream can run at full rate while still honouring m_ready back-pressure.
module stream_skid_buf #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] slot_q [2];
    logic             wrPtr_q;
    logic             wrPtr_d;
    logic             rdPtr_q;
    logic             rdPtr_d;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             doPush;
    logic             doPop;

    // Guard push/pop against full/empty, then derive next pointers and occupancy;
    // a push and pop in the same cycle leave the occupancy where it was
    always_comb begin
        doPush  = push && (count_q != 2'd2);
        doPop   = pop && (count_q != 2'd0);
        wrPtr_d = doPush ? ~wrPtr_q : wrPtr_q;
        rdPtr_d = doPop ? ~rdPtr_q : rdPtr_q;
        count_d = count_q;
        if (doPush && !doPop) begin
            count_d = count_q + 2'd1;
        end else if (doPop && !doPush) begin
            count_d = count_q - 2'd1;
        end
    end

    // Storage and pointers; slots clear on reset so the head reads zero out of reset
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            wrPtr_q   <= 1'b0;
            rdPtr_q   <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (doPush) begin
                slot_q[wrPtr_q] <= push_data;
            end
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    assign head  = slot_q[rdPtr_q];
    assign count = count_q;

endmodule

// File: rtl/ram_stream_ctrl.sv
// Block-transfer controller for a single-port RAM: a command moves a run of
// words either from the s_* stream into RAM or from RAM onto the m_* stream,
// with addresses wrapping modulo DEPTH.
module ram_stream_ctrl
    import ram_stream_pkg::*;
#(
    parameter int WIDTH      = 12,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_dir,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [WIDTH-1:0]      s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [WIDTH-1:0]      m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  done,
    output logic                  ram_wrEn,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [WIDTH-1:0]      ram_dataIn,
    input  logic [WIDTH-1:0]      ram_dataOut
);

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] ptr_d;
    logic [LEN_WIDTH-1:0]  issueLeft_q;
    logic [LEN_WIDTH-1:0]  issueLeft_d;
    logic [LEN_WIDTH-1:0]  popLeft_q;
    logic [LEN_WIDTH-1:0]  popLeft_d;
    logic                  inFlight_q;
    logic                  inFlight_d;

    logic [LEN_WIDTH-1:0]  lenClamped;
    logic                  cmdFire;
    logic                  writeBeat;
    logic                  readIssue;
    logic                  readPop;
    logic [2:0]            slotsUsed;
    logic [1:0]            bufCount;
    logic [WIDTH-1:0]      bufHead;

    // Read words land here one cycle after their address was issued
    stream_skid_buf #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk       (clk),
        .rstN      (rstN),
        .push      (inFlight_q),
        .push_data (ram_dataOut),
        .pop       (readPop),
        .head      (bufHead),
        .count     (bufCount)
    );

    // Lengths beyond the RAM size are treated as one full pass over the RAM
    always_comb begin
        lenClamped = cmd_len;
        if (cmd_len > LEN_WIDTH'(DEPTH)) begin
            lenClamped = LEN_WIDTH'(DEPTH);
        end
    end

    // Current state register; reset abandons any command without a done pulse
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencing: a write ends on its last accepted beat, a read on its last popped word
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cmdFire) begin
                    if (lenClamped == '0) begin
                        state_d = DONE;
                    end else if (dir_t'(cmd_dir) == DIR_WRITE) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            WRITE: begin
                if (writeBeat && (issueLeft_q == LEN_WIDTH'(1))) begin
                    state_d = DONE;
                end
            end
            READ: begin
                if (readPop && (popLeft_q == LEN_WIDTH'(1))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshakes and RAM drive; a word leaving the buffer this cycle frees its
    // slot for a new issue, which is what sustains one word per cycle
    always_comb begin
        cmd_ready  = (state_q == IDLE);
        s_ready    = (state_q == WRITE);
        done       = (state_q == DONE);
        cmdFire    = cmd_ready && cmd_valid;
        writeBeat  = s_ready && s_valid;
        m_valid    = (bufCount != 2'd0);
        m_data     = bufHead;
        readPop    = m_valid && m_ready;
        slotsUsed  = 3'(bufCount) - 3'(readPop) + 3'(inFlight_q);
        readIssue  = (state_q == READ) && (issueLeft_q != '0)
                     && (slotsUsed < 3'(SKID_DEPTH));
        ram_wrEn   = writeBeat;
        ram_addr   = ptr_q;
        ram_dataIn = s_data;
    end

    // Pointer and counters: load on command, advance per written beat or issued read
    always_comb begin
        ptr_d       = ptr_q;
        issueLeft_d = issueLeft_q;
        popLeft_d   = popLeft_q;
        inFlight_d  = readIssue;
        if (cmdFire) begin
            ptr_d       = cmd_addr;
            issueLeft_d = lenClamped;
            popLeft_d   = lenClamped;
        end
        if (writeBeat || readIssue) begin
            if (ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + ADDR_WIDTH'(1);
            end
            issueLeft_d = issueLeft_q - LEN_WIDTH'(1);
        end
        if (readPop) begin
            popLeft_d = popLeft_q - LEN_WIDTH'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ptr_q       <= '0;
            issueLeft_q <= '0;
            popLeft_q   <= '0;
            inFlight_q  <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            issueLeft_q <= issueLeft_d;
            popLeft_q   <= popLeft_d;
            inFlight_q  <= inFlight_d;
        end
    end

endmodule
